piso_serializer: RTL and testbench

- Parametrised, double-buffered parallel-in/serial-out shifter for the serial output path.
- Generalises the existing 40-bit frame-triggered serializer with configurable width, bit order and idle level.
- Adds a holding register so the next word can load while the current word shifts.
- Gapless back-to-back frames, a load-ready handshake and a sticky overrun flag.

---
 rtl/piso_serializer_pkg.sv | 18 +
 rtl/piso_serializer_hold_buf.sv | 50 +++++
 rtl/piso_serializer.sv | 86 ++++++++
 tb/tb_piso_serializer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// Shared constants and helpers for the serial output path (piso serializer and its sipo counterpart).
package piso_serializer_pkg;

  localparam logic IDLE_LOW  = 1'b0;
  localparam logic IDLE_HIGH = 1'b1;

  localparam bit ORDER_MSB = 1'b1;
  localparam bit ORDER_LSB = 1'b0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Counter must hold the full word length, hence n+1.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/piso_serializer_hold_buf.sv
// Holding register in front of the shifter: load handshake, Ready and sticky Overrun.
module piso_hold_buf
  import piso_serializer_pkg::*;
#(
  parameter int DATA_W = 40
) (
  input  logic              Sclk,
  input  logic              Clear,
  input  logic              Load,
  input  logic              start,
  input  logic [DATA_W-1:0] InputParallel,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_valid,
  output logic              Ready,
  output logic              Overrun
);

  logic accept;
  logic hold_valid_next;

  // A load is taken if the slot is empty or is being emptied by a start this edge.
  assign accept = Load && (!hold_valid || start);

  always_comb begin
    hold_valid_next = hold_valid;
    if (accept)
      hold_valid_next = 1'b1;
    else if (start)
      hold_valid_next = 1'b0;
  end

  always_ff @(posedge Sclk) begin
    if (Clear) begin
      hold_valid <= 1'b0;
      Ready      <= 1'b1;
      Overrun    <= 1'b0;
    end else begin
      hold_valid <= hold_valid_next;
      Ready      <= !hold_valid_next;
      if (Load && hold_valid && !start)
        Overrun <= 1'b1;
    end
  end

  always_ff @(posedge Sclk) begin
    if (accept)
      hold_data <= InputParallel;
  end

endmodule

// File: rtl/piso_serializer.sv
// Double-buffered parallel-in/serial-out shifter with gapless back-to-back words.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   DATA_W     = 40,
  parameter bit   MSB_FIRST  = ORDER_MSB,
  parameter logic IDLE_LEVEL = IDLE_LOW
) (
  input  logic              Sclk,
  input  logic              Clear,
  input  logic              Frame,
  input  logic              Load,
  input  logic [DATA_W-1:0] InputParallel,
  output logic              Ready,
  output logic              OutputSerial,
  output logic              OutReady,
  output logic              Overrun
);

  localparam int CNT_W = cnt_width(DATA_W);

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] hold_data;
  logic              hold_valid;
  logic              last_bit;
  logic              start;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  piso_hold_buf #(.DATA_W(DATA_W)) u_hold (
    .Sclk          (Sclk),
    .Clear         (Clear),
    .Load          (Load),
    .start         (start),
    .InputParallel (InputParallel),
    .hold_data     (hold_data),
    .hold_valid    (hold_valid),
    .Ready         (Ready),
    .Overrun       (Overrun)
  );

  // cnt counts bits still to be shown, including the one currently on OutputSerial.
  assign last_bit = (cnt == CNT_W'(1));
  assign start    = Frame && hold_valid && ((state == ST_IDLE) || last_bit);

  always_ff @(posedge Sclk) begin
    if (Clear) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      OutReady     <= 1'b0;
      OutputSerial <= IDLE_LEVEL;
    end else if (start) begin
      state        <= ST_SHIFT;
      cnt          <= CNT_W'(DATA_W);
      OutReady     <= 1'b1;
      OutputSerial <= first_bit(hold_data);
    end else if (state == ST_SHIFT) begin
      if (last_bit) begin
        state        <= ST_IDLE;
        cnt          <= '0;
        OutReady     <= 1'b0;
        OutputSerial <= IDLE_LEVEL;
      end else begin
        cnt          <= cnt - CNT_W'(1);
        OutputSerial <= first_bit(shift_reg);
      end
    end
  end

  // The first bit leaves straight from the holding register, so the shifter keeps the rest.
  always_ff @(posedge Sclk) begin
    if (start)
      shift_reg <= advance(hold_data);
    else if (state == ST_SHIFT)
      shift_reg <= advance(shift_reg);
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: 40-bit MSB-first, 8-bit MSB-first and 8-bit LSB-first instances.
module tb_piso_serializer;

  logic Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  logic [2:0]  clr, ld, fr;
  logic [39:0] din40;
  logic [7:0]  din8m, din8l;
  logic [2:0]  rdy, so, orv, ov;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;
  bit q[3][$];
  int run[3];
  int last_run[3];

  typedef struct {
    logic       clear;
    logic       load;
    logic       frame;
    logic [7:0] din;
    bit         push;
    logic       ready;
    logic       outr;
    logic       ovr;
  } vec_t;
  vec_t tbl[13];

  piso_serializer #(.DATA_W(40), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u40 (
    .Sclk(Sclk), .Clear(clr[0]), .Frame(fr[0]), .Load(ld[0]), .InputParallel(din40),
    .Ready(rdy[0]), .OutputSerial(so[0]), .OutReady(orv[0]), .Overrun(ov[0])
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u8m (
    .Sclk(Sclk), .Clear(clr[1]), .Frame(fr[1]), .Load(ld[1]), .InputParallel(din8m),
    .Ready(rdy[1]), .OutputSerial(so[1]), .OutReady(orv[1]), .Overrun(ov[1])
  );

  piso_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u8l (
    .Sclk(Sclk), .Clear(clr[2]), .Frame(fr[2]), .Load(ld[2]), .InputParallel(din8l),
    .Ready(rdy[2]), .OutputSerial(so[2]), .OutReady(orv[2]), .Overrun(ov[2])
  );

  task automatic tick();
    @(posedge Sclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input int i, input logic [63:0] w, input int n, input bit msb);
    for (int k = 0; k < n; k++)
      q[i].push_back(msb ? w[n-1-k] : w[k]);
  endtask

  task automatic wait_idle(input int i, input int bound);
    int c = 0;
    while (orv[i] === 1'b1 && c < bound) begin
      tick();
      c++;
    end
    if (orv[i] === 1'b1) begin
      tests++;
      fails++;
      $display("FAIL timeout_dut%0d: OutReady still high after %0d cycles", i, bound);
    end
    tick();
  endtask

  // Scoreboard: every valid serial bit must match the next queued expected bit.
  always @(negedge Sclk) begin
    if (mon_on) begin
      for (int i = 0; i < 3; i++) begin
        if (orv[i] === 1'b1) begin
          run[i]++;
          if (q[i].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_bit_dut%0d: serial=%0b with nothing queued", i, so[i]);
          end else begin
            chk($sformatf("bit_dut%0d", i), 64'(so[i]), 64'(q[i].pop_front()));
          end
        end else begin
          if (run[i] != 0) last_run[i] = run[i];
          run[i] = 0;
          chk($sformatf("idle_dut%0d", i), 64'(so[i]), 64'(0));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int i = 0; i < 3; i++) begin
      run[i] = 0;
      last_run[i] = 0;
    end

    // Overrun scenario on the 8-bit MSB instance: {clear,load,frame,din,push,ready,outr,ovr}
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int r = 4; r <= 10; r++)
      tbl[r] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    clr = '1; ld = '0; fr = '0;
    din40 = '0; din8m = '0; din8l = '0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready_dut%0d", i), 64'(rdy[i]), 64'(1));
      chk($sformatf("reset_outready_dut%0d", i), 64'(orv[i]), 64'(0));
      chk($sformatf("reset_overrun_dut%0d", i), 64'(ov[i]), 64'(0));
      chk($sformatf("reset_serial_dut%0d", i), 64'(so[i]), 64'(0));
    end
    clr = '0;
    mon_on = 1'b1;

    // Single 40-bit word, MSB first
    last_run[0] = 0;
    din40 = 40'hA5_0F_C3_81_7E;
    ld[0] = 1'b1;
    push_word(0, 64'(din40), 40, 1'b1);
    tick();
    ld[0] = 1'b0;
    chk("ready_after_load40", 64'(rdy[0]), 64'(0));
    fr[0] = 1'b1;
    tick();
    fr[0] = 1'b0;
    chk("first_bit_latency40", 64'(orv[0]), 64'(1));
    wait_idle(0, 60);
    chk("run_len40", 64'(last_run[0]), 64'(40));

    // LSB-first 8-bit word
    last_run[2] = 0;
    din8l = 8'h01;
    ld[2] = 1'b1;
    push_word(2, 64'(din8l), 8, 1'b0);
    tick();
    ld[2] = 1'b0;
    fr[2] = 1'b1;
    tick();
    fr[2] = 1'b0;
    wait_idle(2, 20);
    chk("run_len8_lsb", 64'(last_run[2]), 64'(8));

    // Table: overrun is sticky, dropped word never reaches the line
    for (int r = 0; r < 13; r++) begin
      clr[1] = tbl[r].clear;
      ld[1]  = tbl[r].load;
      fr[1]  = tbl[r].frame;
      din8m  = tbl[r].din;
      if (tbl[r].push) push_word(1, 64'(tbl[r].din), 8, 1'b1);
      tick();
      chk($sformatf("row%0d_ready", r), 64'(rdy[1]), 64'(tbl[r].ready));
      chk($sformatf("row%0d_outready", r), 64'(orv[1]), 64'(tbl[r].outr));
      chk($sformatf("row%0d_overrun", r), 64'(ov[1]), 64'(tbl[r].ovr));
    end
    clr[1] = 1'b0; ld[1] = 1'b0; fr[1] = 1'b0;

    // Gapless chain: second word loaded during the first, Frame held high
    last_run[1] = 0;
    din8m = 8'hF0;
    ld[1] = 1'b1;
    push_word(1, 64'(din8m), 8, 1'b1);
    tick();
    ld[1] = 1'b0;
    fr[1] = 1'b1;
    tick();
    chk("chain_first_start", 64'(orv[1]), 64'(1));
    din8m = 8'h0F;
    ld[1] = 1'b1;
    push_word(1, 64'(din8m), 8, 1'b1);
    tick();
    ld[1] = 1'b0;
    chk("chain_hold_full", 64'(rdy[1]), 64'(0));
    c = 0;
    while (rdy[1] !== 1'b1 && c < 12) begin
      tick();
      c++;
    end
    chk("chain_ready_back", 64'(rdy[1]), 64'(1));
    chk("chain_outready_kept", 64'(orv[1]), 64'(1));
    fr[1] = 1'b0;
    wait_idle(1, 30);
    chk("chain_run_len16", 64'(last_run[1]), 64'(16));

    // Frame with empty hold does nothing; a late load starts one edge later
    last_run[1] = 0;
    fr[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("frame_nodata_%0d", k), 64'(orv[1]), 64'(0));
    end
    din8m = 8'h3C;
    ld[1] = 1'b1;
    push_word(1, 64'(din8m), 8, 1'b1);
    tick();
    ld[1] = 1'b0;
    chk("late_load_no_start_yet", 64'(orv[1]), 64'(0));
    tick();
    chk("late_load_started", 64'(orv[1]), 64'(1));
    chk("late_load_first_bit", 64'(so[1]), 64'(0));
    fr[1] = 1'b0;
    wait_idle(1, 20);
    chk("late_load_run_len8", 64'(last_run[1]), 64'(8));

    // Clear at bit 17 of a 40-bit word
    din40 = 40'h12_34_56_78_9A;
    ld[0] = 1'b1;
    push_word(0, 64'(din40), 40, 1'b1);
    tick();
    ld[0] = 1'b0;
    fr[0] = 1'b1;
    tick();
    fr[0] = 1'b0;
    repeat (16) tick();
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    q[0].delete();
    chk("clear_mid_outready", 64'(orv[0]), 64'(0));
    chk("clear_mid_serial", 64'(so[0]), 64'(0));
    chk("clear_mid_ready", 64'(rdy[0]), 64'(1));
    fr[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("clear_then_frame_%0d", k), 64'(orv[0]), 64'(0));
    end
    fr[0] = 1'b0;
    tick();

    for (int i = 0; i < 3; i++)
      chk($sformatf("queue_drained_dut%0d", i), 64'(q[i].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
